matrix_gen_engine: RTL and testbench
====================================

// Module: matrix_gen_engine
// PURPOSE
//   Parametrised matrix generator for the calculator datapath. Takes a request of
//   up to 2**CNT_WIDTH-1 matrices (m x n, fill mode), allocates a slot for each through
//   the matrix manager and writes elements to BRAM. Echoes each matrix over a
//   ready/valid byte stream as zero-suppressed hex, then commits it. Successor to the
//   single-matrix UART generate flow; adds fill modes, rejection-sampled range, batch count.
// PARAMETERS
//   ELEMENT_WIDTH  8   element bits; must be a multiple of 4; hex digits = ELEMENT_WIDTH/4
//   ADDR_WIDTH     10  BRAM address bits
//   DIM_WIDTH      4   bits of m, n and cfg_max_dim
//   CNT_WIDTH      3   bits of req_count
//   MAX_TRIES      16  rejection-sampling attempts before fallback
// PORTS
//   clk            in   1            system clock
//   rst            in   1            synchronous, active-high reset
//   start          in   1            request pulse; sampled in IDLE only
//   abort          in   1            cancel the current request
//   req_m, req_n   in   DIM_WIDTH    matrix dimensions
//   req_count      in   CNT_WIDTH    number of matrices to generate
//   req_mode       in   2            0 random, 1 zero, 2 identity, 3 constant(=cfg_max_value)
//   cfg_max_dim    in   DIM_WIDTH    upper bound for m and n
//   cfg_max_value  in   ELEMENT_WIDTH upper bound for element values (inclusive)
//   rand_in        in   ELEMENT_WIDTH free-running LFSR value, new value every cycle
//   alloc_req      out  1            slot request, held until alloc_valid/alloc_fail
//   alloc_valid    in   1            grant; alloc_slot and alloc_addr are valid
//   alloc_fail     in   1            no free slot
//   alloc_slot     in   4            granted slot
//   alloc_addr     in   ADDR_WIDTH   granted base address
//   commit_req     out  1            one-cycle pulse; commit_* fields valid in the same cycle
//   commit_slot/m/n/addr  out  4/DIM_WIDTH/DIM_WIDTH/ADDR_WIDTH
//   mem_wr_en      out  1            one-cycle write strobe
//   mem_wr_addr    out  ADDR_WIDTH   base + row*n + col
//   mem_wr_data    out  ELEMENT_WIDTH element value
//   tx_data        out  8            ASCII byte
//   tx_valid       out  1            held with tx_data stable until tx_ready
//   tx_ready       in   1            byte transfers when tx_valid && tx_ready
//   busy           out  1            high in every state except IDLE
//   done           out  1            one-cycle pulse at the end of the request (success or error)
//   error_code     out  3            0 none, 1 dim, 2 alloc, 3 mode, 4 abort; held until next start
// BEHAVIOUR
//   Reset: every output is 0, state is IDLE. Reset mid-request drops the request: no commit.
//   States: IDLE -> CHECK -> ALLOC -> SAMPLE -> WRITE -> TX_DIG -> TX_SEP -> (SAMPLE | COMMIT)
//     COMMIT -> (ALLOC for the next matrix | FINISH); FINISH -> IDLE with done=1.
//   CHECK, one cycle:
//     m==0, n==0, m>cfg_max_dim, n>cfg_max_dim or count==0 -> error 1.
//     mode 2 with m!=n -> error 3.
//     Any error -> FINISH with no allocation.
//   ALLOC: alloc_fail -> error 2, FINISH. Matrices already committed stay committed.
//   SAMPLE:
//     mode 0: accept rand_in if rand_in <= cfg_max_value; otherwise retry the next cycle.
//       After MAX_TRIES rejects, use rand_in & cfg_max_value, then clamp to cfg_max_value.
//     Modes 1 and 3 take one cycle.
//     Mode 2: value is 1 when row==col, else 0.
//   WRITE: mem_wr_en=1 for exactly one cycle per element, in row-major order.
//   TX_DIG: hex digits, MSB first, uppercase A-F. Leading zeros are suppressed, but the
//     value 0 sends "0". Each byte waits for tx_ready; no byte is dropped or duplicated.
//   TX_SEP separators:
//     space (0x20) after a non-last column; 0x0A after the last column.
//     After the final row an extra 0x0A is sent, so matrices are separated by a blank line.
//   COMMIT: commit_req pulses once, after the last byte of the matrix has been accepted.
//   abort in any non-IDLE state: error 4, FINISH next cycle, current matrix not committed.
//     If abort and start coincide in IDLE, start wins and abort is ignored.
//   start while busy is ignored. The req_* and cfg_* inputs are latched on the start cycle.
//   Index counters wrap to 0 between matrices. The element index is never compared
//     against an m*n product wider than 2*DIM_WIDTH.
// TESTING
//   1. m=2,n=3,count=1,mode1, tx_ready=1 -> 6 writes of 0 at base..base+5; tx "0 0 0\n0 0 0\n\n"; 1 commit; done, err 0.
//   2. m=3,n=3,mode2, tx_ready toggling 1-in-3 -> diagonal 1s written; stream "1 0 0\n0 1 0\n0 0 1\n\n" exact.
//   3. mode0, cfg_max_value=5, rand_in forced to 9 for 20 cycles -> 16 rejects, then value 9&5=1; writes 1.
//   4. count=3, alloc_fail on the second request -> one commit, error 2, done pulse, busy low.
//   5. m=cfg_max_dim+1 -> error 1 with no alloc_req; mode2 m=2,n=3 -> error 3.
//   6. abort during TX of element 4, and a separate rst=1 mid-write -> no commit, all outputs 0, IDLE.

Source files
------------

// File: rtl/matrix_gen_engine.sv
// matrix_gen_engine
//   Generates a batch of m x n matrices. For each matrix it requests a slot from
//   the matrix manager, produces every element in row-major order (random with
//   rejection sampling, zero, identity or constant), writes it to BRAM, echoes it
//   as zero-suppressed uppercase hex over a ready/valid byte stream and finally
//   commits the slot. The request ends with a one-cycle done pulse and an error code.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                request pulse (IDLE only), cancel current request
//   req_m/n/count/mode          request fields, latched on start
//   cfg_max_dim, cfg_max_value  dimension and element-value limits, latched on start
//   rand_in                     free-running random value
//   alloc_*                     slot allocation handshake with the matrix manager
//   commit_*                    one-cycle commit of a finished matrix
//   mem_wr_*                    BRAM element write port
//   tx_data/valid/ready         ASCII byte stream
//   busy, done, error_code      status (0 none, 1 dim, 2 alloc, 3 mode, 4 abort)
module matrix_gen_engine #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int DIM_WIDTH     = 4,
  parameter int CNT_WIDTH     = 3,
  parameter int MAX_TRIES     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIM_WIDTH-1:0]     req_m,
  input  logic [DIM_WIDTH-1:0]     req_n,
  input  logic [CNT_WIDTH-1:0]     req_count,
  input  logic [1:0]               req_mode,
  input  logic [DIM_WIDTH-1:0]     cfg_max_dim,
  input  logic [ELEMENT_WIDTH-1:0] cfg_max_value,
  input  logic [ELEMENT_WIDTH-1:0] rand_in,
  output logic                     alloc_req,
  input  logic                     alloc_valid,
  input  logic                     alloc_fail,
  input  logic [3:0]               alloc_slot,
  input  logic [ADDR_WIDTH-1:0]    alloc_addr,
  output logic                     commit_req,
  output logic [3:0]               commit_slot,
  output logic [DIM_WIDTH-1:0]     commit_m,
  output logic [DIM_WIDTH-1:0]     commit_n,
  output logic [ADDR_WIDTH-1:0]    commit_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               error_code
);

  localparam int NDIG  = ELEMENT_WIDTH / 4;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [DIM_WIDTH-1:0]     DIM_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = 1;
  localparam logic [ELEMENT_WIDTH-1:0] EL_ONE   = 1;
  localparam logic [DIG_W-1:0]         DIG_ONE  = 1;
  localparam logic [TRY_W-1:0]         TRY_ONE  = 1;
  localparam logic [TRY_W-1:0]         TRY_MAX  = TRY_W'(MAX_TRIES);

  localparam logic [1:0] MODE_RAND  = 2'd0;
  localparam logic [1:0] MODE_ZERO  = 2'd1;
  localparam logic [1:0] MODE_IDENT = 2'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_DIM   = 3'd1;
  localparam logic [2:0] ERR_ALLOC = 3'd2;
  localparam logic [2:0] ERR_MODE  = 3'd3;
  localparam logic [2:0] ERR_ABORT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ALLOC, S_SAMPLE, S_WRITE, S_TX_DIG, S_TX_SEP, S_COMMIT, S_FINISH
  } state_t;

  function automatic logic [ELEMENT_WIDTH-1:0] clamp_val(input logic [ELEMENT_WIDTH-1:0] v,
                                                         input logic [ELEMENT_WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Index of the most significant non-zero hex digit; 0 for the value 0 so it still prints "0".
  function automatic logic [DIG_W-1:0] lead_digit(input logic [ELEMENT_WIDTH-1:0] v);
    logic [DIG_W-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++)
      if (v[i*4 +: 4] != 4'h0) r = DIG_W'(i);
    return r;
  endfunction

  function automatic logic [3:0] get_digit(input logic [ELEMENT_WIDTH-1:0] v,
                                           input logic [DIG_W-1:0] idx);
    logic [3:0] d;
    d = 4'h0;
    for (int i = 0; i < NDIG; i++)
      if (DIG_W'(i) == idx) d = v[i*4 +: 4];
    return d;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  state_t                   r_state, w_next;
  logic [2:0]               r_err, w_err_code;
  logic                     w_set_err;
  logic [DIM_WIDTH-1:0]     r_m, r_n, r_max_dim, r_row, r_col;
  logic [CNT_WIDTH-1:0]     r_count, r_mat;
  logic [1:0]               r_mode;
  logic [ELEMENT_WIDTH-1:0] r_max_val, r_val;
  logic [ADDR_WIDTH-1:0]    r_base, r_off;
  logic [3:0]               r_slot;
  logic [TRY_W-1:0]         r_tries;
  logic [DIG_W-1:0]         r_dig;
  logic                     r_extra;
  logic                     w_last_col, w_last_row, w_accept, w_dim_bad;

  assign w_last_col = (r_col == r_n - DIM_ONE);
  assign w_last_row = (r_row == r_m - DIM_ONE);
  // A random draw is taken when in range, or unconditionally once the reject budget is spent.
  assign w_accept   = (r_tries == TRY_MAX) || (rand_in <= r_max_val);
  assign w_dim_bad  = (r_m == '0) || (r_n == '0) || (r_m > r_max_dim) ||
                      (r_n > r_max_dim) || (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_set_err  = 1'b0;
    w_err_code = ERR_NONE;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (w_dim_bad) begin
          w_next = S_FINISH; w_set_err = 1'b1; w_err_code = ERR_DIM;
        end else if (r_mode == MODE_IDENT && r_m != r_n) begin
          w_next = S_FINISH; w_set_err = 1'b1; w_err_code = ERR_MODE;
        end else begin
          w_next = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (alloc_valid) w_next = S_SAMPLE;
        else if (alloc_fail) begin
          w_next = S_FINISH; w_set_err = 1'b1; w_err_code = ERR_ALLOC;
        end
      end
      S_SAMPLE: if (r_mode != MODE_RAND || w_accept) w_next = S_WRITE;
      S_WRITE:  w_next = S_TX_DIG;
      S_TX_DIG: if (tx_ready && r_dig == '0) w_next = S_TX_SEP;
      S_TX_SEP: begin
        if (tx_ready) begin
          if (!(w_last_col && w_last_row)) w_next = S_SAMPLE;
          else if (r_extra)                w_next = S_COMMIT;
        end
      end
      S_COMMIT: w_next = (r_mat + CNT_ONE == r_count) ? S_FINISH : S_ALLOC;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // FINISH already ends the request, so abort there would only duplicate done.
    if (r_state != S_IDLE && r_state != S_FINISH && abort) begin
      w_next = S_FINISH; w_set_err = 1'b1; w_err_code = ERR_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_err <= ERR_NONE;
    else if (r_state == S_IDLE && start) r_err <= ERR_NONE;
    else if (w_set_err)               r_err <= w_err_code;
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_m <= req_m; r_n <= req_n; r_count <= req_count; r_mode <= req_mode;
          r_max_dim <= cfg_max_dim; r_max_val <= cfg_max_value;
        end
        r_mat <= '0;
      end
      S_ALLOC: begin
        if (alloc_valid) begin
          r_slot <= alloc_slot; r_base <= alloc_addr;
          r_row <= '0; r_col <= '0; r_off <= '0; r_extra <= 1'b0; r_tries <= '0;
        end
      end
      S_SAMPLE: begin
        case (r_mode)
          MODE_RAND: begin
            if (r_tries == TRY_MAX)        r_val <= clamp_val(rand_in & r_max_val, r_max_val);
            else if (rand_in <= r_max_val) r_val <= rand_in;
            else                           r_tries <= r_tries + TRY_ONE;
          end
          MODE_ZERO:  r_val <= '0;
          MODE_IDENT: r_val <= (r_row == r_col) ? EL_ONE : '0;
          default:    r_val <= r_max_val;
        endcase
      end
      S_WRITE: begin
        r_dig   <= lead_digit(r_val);
        r_off   <= r_off + ADDR_ONE;
        r_tries <= '0;
      end
      S_TX_DIG: if (tx_ready && r_dig != '0) r_dig <= r_dig - DIG_ONE;
      S_TX_SEP: begin
        if (tx_ready) begin
          if (!w_last_col) r_col <= r_col + DIM_ONE;
          else if (!w_last_row) begin
            r_col <= '0; r_row <= r_row + DIM_ONE;
          end else r_extra <= 1'b1;
        end
      end
      S_COMMIT: r_mat <= r_mat + CNT_ONE;
      default: ;
    endcase
  end

  // Outputs decode from state; data fields are forced to 0 outside their strobes.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign error_code  = r_err;
  assign alloc_req   = (r_state == S_ALLOC);
  assign commit_req  = (r_state == S_COMMIT);
  assign commit_slot = commit_req ? r_slot : '0;
  assign commit_m    = commit_req ? r_m    : '0;
  assign commit_n    = commit_req ? r_n    : '0;
  assign commit_addr = commit_req ? r_base : '0;
  assign mem_wr_en   = (r_state == S_WRITE);
  assign mem_wr_addr = mem_wr_en ? (r_base + r_off) : '0;
  assign mem_wr_data = mem_wr_en ? r_val : '0;
  assign tx_valid    = (r_state == S_TX_DIG) || (r_state == S_TX_SEP);
  assign tx_data     = (r_state == S_TX_DIG) ? hex_ascii(get_digit(r_val, r_dig)) :
                       (r_state == S_TX_SEP) ? (w_last_col ? 8'h0A : 8'h20) : 8'h00;

endmodule

// File: tb/tb_matrix_gen_engine.sv
module tb_matrix_gen_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic [3:0] req_m = '0, req_n = '0, cfg_max_dim = '0;
  logic [2:0] req_count = '0;
  logic [1:0] req_mode = '0;
  logic [7:0] cfg_max_value = '0, rand_in = '0;
  logic       alloc_req, alloc_valid = 1'b0, alloc_fail = 1'b0;
  logic [3:0] alloc_slot = '0;
  logic [9:0] alloc_addr = '0;
  logic       commit_req;
  logic [3:0] commit_slot, commit_m, commit_n;
  logic [9:0] commit_addr;
  logic       mem_wr_en;
  logic [9:0] mem_wr_addr;
  logic [7:0] mem_wr_data, tx_data;
  logic       tx_valid, tx_ready = 1'b1;
  logic       busy, done;
  logic [2:0] error_code;

  matrix_gen_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .req_m(req_m), .req_n(req_n), .req_count(req_count), .req_mode(req_mode),
    .cfg_max_dim(cfg_max_dim), .cfg_max_value(cfg_max_value), .rand_in(rand_in),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_fail(alloc_fail),
    .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
    .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
    .commit_n(commit_n), .commit_addr(commit_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Environment: matrix-manager model, stream sink and write/commit recorder, all at negedge.
  int         cyc = 0, alloc_cnt = 0, fail_on = 0, grant_cyc = 0, done_cnt = 0;
  int         cmt_cnt = 0, cmt_slot = 0, cmt_addr = 0, cmt_m = 0, cmt_n = 0;
  bit         ready_div = 1'b0;
  logic [7:0] rand_val = '0;
  logic [7:0] tx_q[$];
  int         wa_q[$], wd_q[$], wc_q[$];

  always @(negedge clk) begin
    cyc++;
    tx_ready = ready_div ? (cyc % 3 == 0) : 1'b1;
    rand_in  = rand_val;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (mem_wr_en) begin
      wa_q.push_back(int'(mem_wr_addr)); wd_q.push_back(int'(mem_wr_data)); wc_q.push_back(cyc);
    end
    if (commit_req) begin
      cmt_cnt++; cmt_slot = int'(commit_slot); cmt_addr = int'(commit_addr);
      cmt_m = int'(commit_m); cmt_n = int'(commit_n);
    end
    if (done) done_cnt++;
    alloc_valid = 1'b0; alloc_fail = 1'b0;
    if (alloc_req) begin
      alloc_cnt++;
      if (alloc_cnt == fail_on) alloc_fail = 1'b1;
      else begin
        alloc_valid = 1'b1; alloc_slot = 4'(alloc_cnt);
        alloc_addr = 10'(40 * alloc_cnt + 7); grant_cyc = cyc;
      end
    end
  end

  int m_tx, m_wr, m_cmt, m_done, m_alloc;

  task automatic start_req(input int m, input int n, input int cnt, input int mode,
                           input int maxdim, input int maxval, input bit with_abort);
    @(posedge clk); #1;
    m_tx = tx_q.size(); m_wr = wa_q.size(); m_cmt = cmt_cnt; m_done = done_cnt; m_alloc = alloc_cnt;
    req_m = 4'(m); req_n = 4'(n); req_count = 3'(cnt); req_mode = 2'(mode);
    cfg_max_dim = 4'(maxdim); cfg_max_value = 8'(maxval);
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > m_done) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_timeout"}, int'(timed_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done_cnt - m_done, 1);
  endtask

  task automatic chk_tx(input string tag, input string exp);
    chk({tag, "_txlen"}, tx_q.size() - m_tx, exp.len());
    for (int i = 0; i < exp.len() && m_tx + i < tx_q.size(); i++)
      chk({tag, "_txbyte"}, int'(tx_q[m_tx + i]), int'(exp[i]));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(error_code), 0);
    chk({tag, "_alloc_req"}, int'(alloc_req), 0);
    chk({tag, "_commit"}, int'({commit_req, commit_slot, commit_m, commit_n, commit_addr}), 0);
    chk({tag, "_mem"}, int'({mem_wr_en, mem_wr_addr, mem_wr_data}), 0);
    chk({tag, "_tx"}, int'({tx_valid, tx_data}), 0);
  endtask

  initial begin
    int base;
    bit hit;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // 2x3 zero matrix, always-ready sink
    start_req(2, 3, 1, 1, 8, 5, 1'b0);
    wait_done("t1", 200);
    base = 40 * (m_alloc + 1) + 7;
    chk("t1_err", int'(error_code), 0);
    chk("t1_nwr", wa_q.size() - m_wr, 6);
    for (int i = 0; i < 6 && m_wr + i < wa_q.size(); i++) begin
      chk("t1_wr_addr", wa_q[m_wr + i], base + i);
      chk("t1_wr_data", wd_q[m_wr + i], 0);
    end
    chk_tx("t1", "0 0 0\n0 0 0\n\n");
    chk("t1_commits", cmt_cnt - m_cmt, 1);
    chk("t1_cmt_slot", cmt_slot, m_alloc + 1);
    chk("t1_cmt_addr", cmt_addr, base);
    chk("t1_cmt_mn", cmt_m * 16 + cmt_n, 2 * 16 + 3);

    // 3x3 identity with a sink that accepts one cycle in three
    ready_div = 1'b1;
    start_req(3, 3, 1, 2, 8, 5, 1'b0);
    wait_done("t2", 600);
    ready_div = 1'b0;
    base = 40 * (m_alloc + 1) + 7;
    chk("t2_err", int'(error_code), 0);
    chk("t2_nwr", wa_q.size() - m_wr, 9);
    for (int i = 0; i < 9 && m_wr + i < wa_q.size(); i++) begin
      chk("t2_wr_addr", wa_q[m_wr + i], base + i);
      chk("t2_wr_data", wd_q[m_wr + i], (i / 3 == i % 3) ? 1 : 0);
    end
    chk_tx("t2", "1 0 0\n0 1 0\n0 0 1\n\n");
    chk("t2_commits", cmt_cnt - m_cmt, 1);

    // random mode, every draw out of range: 16 rejects then 9 & 5 = 1
    rand_val = 8'd9;
    start_req(1, 1, 1, 0, 8, 5, 1'b0);
    wait_done("t3", 200);
    chk("t3_nwr", wa_q.size() - m_wr, 1);
    if (wa_q.size() > m_wr) begin
      chk("t3_wr_data", wd_q[m_wr], 1);
      chk("t3_sample_cycles", wc_q[m_wr] - grant_cyc, 18);
    end
    chk_tx("t3", "1\n\n");

    // random mode, in-range draw accepted at once
    rand_val = 8'd3;
    start_req(1, 1, 1, 0, 8, 5, 1'b0);
    wait_done("t3b", 200);
    chk("t3b_nwr", wa_q.size() - m_wr, 1);
    if (wa_q.size() > m_wr) begin
      chk("t3b_wr_data", wd_q[m_wr], 3);
      chk("t3b_sample_cycles", wc_q[m_wr] - grant_cyc, 2);
    end
    chk_tx("t3b", "3\n\n");

    // constant mode: two-digit uppercase hex, and leading-zero suppression
    start_req(1, 2, 1, 3, 8, 8'hA5, 1'b0);
    wait_done("t_hex", 200);
    chk_tx("t_hexA5", "A5 A5\n\n");
    start_req(1, 1, 1, 3, 8, 8'h0C, 1'b0);
    wait_done("t_hex0C", 200);
    chk_tx("t_hex0C", "C\n\n");

    // batch of 3, second allocation fails
    fail_on = alloc_cnt + 2;
    start_req(1, 1, 3, 1, 8, 5, 1'b0);
    wait_done("t4", 300);
    fail_on = 0;
    chk("t4_err", int'(error_code), 2);
    chk("t4_commits", cmt_cnt - m_cmt, 1);
    chk("t4_allocs", alloc_cnt - m_alloc, 2);

    // argument errors: no allocation attempted
    start_req(5, 2, 1, 1, 4, 5, 1'b0);
    wait_done("t5_dim", 50);
    chk("t5_dim_err", int'(error_code), 1);
    chk("t5_dim_allocs", alloc_cnt - m_alloc, 0);
    chk("t5_dim_nwr", wa_q.size() - m_wr, 0);
    start_req(2, 3, 1, 2, 8, 5, 1'b0);
    wait_done("t5_mode", 50);
    chk("t5_mode_err", int'(error_code), 3);
    chk("t5_mode_allocs", alloc_cnt - m_alloc, 0);
    start_req(2, 2, 0, 1, 8, 5, 1'b0);
    wait_done("t5_cnt", 50);
    chk("t5_cnt_err", int'(error_code), 1);
    start_req(4, 1, 1, 1, 4, 5, 1'b0);
    wait_done("t5_edge", 100);
    chk("t5_edge_err", int'(error_code), 0);
    chk("t5_edge_nwr", wa_q.size() - m_wr, 4);

    // abort while the fourth element is on the stream
    start_req(2, 3, 1, 1, 8, 5, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wa_q.size() - m_wr >= 4 && tx_valid) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t6_abort_point", int'(hit), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("t6_abort", 20);
    chk("t6_abort_err", int'(error_code), 4);
    chk("t6_abort_commits", cmt_cnt - m_cmt, 0);

    // start and abort together in IDLE: start wins
    start_req(1, 1, 1, 1, 8, 5, 1'b1);
    wait_done("t6_coincide", 100);
    chk("t6_coincide_err", int'(error_code), 0);
    chk("t6_coincide_commits", cmt_cnt - m_cmt, 1);

    // reset during the third write
    start_req(3, 3, 1, 1, 8, 5, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_wr_en && wa_q.size() - m_wr >= 2) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t6_rst_point", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("t6_rst");
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_rst_commits", cmt_cnt - m_cmt, 0);
    chk("t6_rst_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
